// File: rtl/triangle_checker_pkg.sv
// Shared types and helpers for the triangle stream checker.
package triangle_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACQUIRE = 2'd1,
    UP      = 2'd2,
    DOWN    = 2'd3
  } tri_state_t;

  function automatic int unsigned tri_max(input int unsigned n);
    return (32'd1 << n) - 32'd1;
  endfunction

endpackage

// File: rtl/triangle_checker_if.sv
// Sample stream in, lock/turn/period status out.
interface triangle_checker_if #(
  parameter int unsigned N = 8,
  parameter int unsigned P = N + 2
);
  logic         ena;
  logic [N-1:0] in;
  logic         locked;
  logic         dir;
  logic         peak;
  logic         valley;
  logic         error;
  logic [P-1:0] period;
  logic         period_valid;
  logic [15:0]  err_count;

  modport master (
    output ena, in,
    input  locked, dir, peak, valley, error, period, period_valid, err_count
  );

  modport slave (
    input  ena, in,
    output locked, dir, peak, valley, error, period, period_valid, err_count
  );
endinterface

// File: rtl/triangle_checker_sat_counter.sv
// Up-counter with synchronous clear (priority) and saturation at all-ones.
module sat_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en_i,
  input  logic         clr_i,
  output logic [W-1:0] cnt_o
);
  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)
      cnt_d = '0;
    else if (en_i && (cnt_q != '1))
      cnt_d = cnt_q + W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;
endmodule

// File: rtl/triangle_checker.sv
// Locks onto a 0..MAX..0 triangle stream; reports turns, valley-to-valley period, errors.
// Optional TRI_CHECK_ERRCNT_EN adds a saturating 16-bit error counter.
module triangle_checker
  import triangle_pkg::*;
#(
  parameter int unsigned N = 8,
  parameter int unsigned P = N + 2
) (
  input  logic             clk,
  input  logic             rst,
  triangle_checker_if.slave bus
);
  localparam logic [N-1:0] MAX = N'(tri_max(N));

  tri_state_t   state_q, state_d;
  logic [N-1:0] prev_q, prev_d;
  logic         first_valley_q, first_valley_d;
  logic         locked_q, locked_d;
  logic         dir_q, dir_d;
  logic         peak_q, peak_d;
  logic         valley_q, valley_d;
  logic         error_q, error_d;
  logic         pv_q, pv_d;
  logic [P-1:0] period_q, period_d;
  logic [P-1:0] cnt;
  logic         cnt_en, cnt_clr;
  logic [N:0]   ext_in, ext_prev;
  logic         step_up, step_dn, turn_peak, turn_valley;

  // Widened compare so MAX<->0 wraparound never looks like a +/-1 step
  assign ext_in      = {1'b0, bus.in};
  assign ext_prev    = {1'b0, prev_q};
  assign step_up     = (ext_in == ext_prev + (N+1)'(1));
  assign step_dn     = (ext_in + (N+1)'(1) == ext_prev);
  assign turn_peak   = (prev_q == MAX) && (bus.in == MAX - N'(1));
  assign turn_valley = (prev_q == '0) && (bus.in == N'(1));

  always_comb begin
    state_d        = state_q;
    prev_d         = prev_q;
    first_valley_d = first_valley_q;
    peak_d         = 1'b0;
    valley_d       = 1'b0;
    error_d        = 1'b0;
    pv_d           = 1'b0;
    period_d       = period_q;
    cnt_en         = 1'b0;
    cnt_clr        = 1'b0;
    if (bus.ena) begin
      prev_d = bus.in;
      cnt_en = (state_q == UP) || (state_q == DOWN);
      unique case (state_q)
        IDLE:    state_d = ACQUIRE;
        ACQUIRE: begin
          if (step_up)      state_d = UP;
          else if (step_dn) state_d = DOWN;
          else              error_d = 1'b1;
        end
        UP: begin
          if (step_up) state_d = UP;
          else if (turn_peak) begin
            state_d = DOWN;
            peak_d  = 1'b1;
          end else begin
            state_d = ACQUIRE;
            error_d = 1'b1;
          end
        end
        DOWN: begin
          if (step_dn) state_d = DOWN;
          else if (turn_valley) begin
            state_d        = UP;
            valley_d       = 1'b1;
            cnt_clr        = 1'b1;
            first_valley_d = 1'b0;
            if (!first_valley_q) begin
              pv_d     = 1'b1;
              period_d = (cnt == '1) ? cnt : cnt + P'(1);
            end
          end else begin
            state_d = ACQUIRE;
            error_d = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
      if (error_d) begin
        cnt_clr        = 1'b1;
        first_valley_d = 1'b1;
      end
    end
    locked_d = (state_d == UP) || (state_d == DOWN);
    dir_d    = (state_d == UP);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      prev_q         <= '0;
      first_valley_q <= 1'b1;
      locked_q       <= 1'b0;
      dir_q          <= 1'b0;
      peak_q         <= 1'b0;
      valley_q       <= 1'b0;
      error_q        <= 1'b0;
      pv_q           <= 1'b0;
      period_q       <= '0;
    end else begin
      state_q        <= state_d;
      prev_q         <= prev_d;
      first_valley_q <= first_valley_d;
      locked_q       <= locked_d;
      dir_q          <= dir_d;
      peak_q         <= peak_d;
      valley_q       <= valley_d;
      error_q        <= error_d;
      pv_q           <= pv_d;
      period_q       <= period_d;
    end
  end

  sat_counter #(.W(P)) u_period_cnt (
    .clk   (clk),
    .rst   (rst),
    .en_i  (cnt_en),
    .clr_i (cnt_clr),
    .cnt_o (cnt)
  );

`ifdef TRI_CHECK_ERRCNT_EN
  logic [15:0] err_cnt;
  sat_counter #(.W(16)) u_err_cnt (
    .clk   (clk),
    .rst   (rst),
    .en_i  (error_d),
    .clr_i (1'b0),
    .cnt_o (err_cnt)
  );
  assign bus.err_count = err_cnt;
`else
  assign bus.err_count = '0;
`endif

  assign bus.locked       = locked_q;
  assign bus.dir          = dir_q;
  assign bus.peak         = peak_q;
  assign bus.valley       = valley_q;
  assign bus.error        = error_q;
  assign bus.period       = period_q;
  assign bus.period_valid = pv_q;
endmodule

// File: tb/tb_triangle_checker.sv
// Directed bench for triangle_checker at N=4 (MAX=15, ideal period 30).
module tb_triangle_checker;
  localparam int unsigned N = 4;
  localparam int unsigned P = N + 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  triangle_checker_if #(.N(N), .P(P)) bus ();

  triangle_checker #(.N(N), .P(P)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int unsigned n_total, n_pass;
  int unsigned n_peak, n_valley, n_err, n_pv, n_idle_pulse;
  int unsigned peak_at, valley_at, last_period;

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    n_total++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic clr_acc();
    n_peak = 0; n_valley = 0; n_err = 0; n_pv = 0; n_idle_pulse = 0;
    peak_at = 99; valley_at = 99; last_period = 0;
  endtask

  task automatic step(input logic e, input logic [N-1:0] v);
    bus.ena = e;
    bus.in  = v;
    @(posedge clk);
    #1;
    if (bus.peak)   begin n_peak++;   peak_at   = v; end
    if (bus.valley) begin n_valley++; valley_at = v; end
    if (bus.error)  n_err++;
    if (bus.period_valid) begin n_pv++; last_period = bus.period; end
    if (!e && (bus.peak || bus.valley || bus.error || bus.period_valid)) n_idle_pulse++;
  endtask

  task automatic feed(input int v, input bit tog);
    step(1'b1, N'(v));
    if (tog) step(1'b0, N'(15 - v));
  endtask

  // From sample 2 onward: up to 15, down to 0, up to 15, down to 0, then the closing 1
  task automatic run_rest(input bit tog);
    for (int v = 2; v <= 15; v++) feed(v, tog);
    for (int v = 14; v >= 0; v--) feed(v, tog);
    for (int v = 1; v <= 15; v++) feed(v, tog);
    for (int v = 14; v >= 0; v--) feed(v, tog);
    feed(1, tog);
  endtask

  task automatic do_reset();
    bus.ena = 1'b0;
    rst = 1'b1;
    #2;
    @(posedge clk);
    #1;
    rst = 1'b0;
    clr_acc();
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_flags"}, {bus.locked, bus.dir, bus.peak, bus.valley, bus.error, bus.period_valid}, 0);
    check({tag, "_period"}, bus.period, 0);
    check({tag, "_errcnt"}, bus.err_count, 0);
  endtask

  initial begin
    n_total = 0; n_pass = 0;
    rst = 1'b1; bus.ena = 1'b0; bus.in = '0;
    clr_acc();
    #12;
    check_idle_outputs("reset");
    do_reset();

    // 1: clean stream, ena held high
    step(1'b1, 4'd0);
    check("t1_lock_after_1st", bus.locked, 0);
    step(1'b1, 4'd1);
    check("t1_lock_after_2nd", bus.locked, 1);
    check("t1_dir_up", bus.dir, 1);
    run_rest(1'b0);
    check("t1_peaks", n_peak, 2);
    check("t1_peak_on_14", peak_at, 14);
    check("t1_valleys", n_valley, 2);
    check("t1_valley_on_1", valley_at, 1);
    check("t1_pv_count", n_pv, 1);
    check("t1_period", last_period, 30);
    check("t1_period_out", bus.period, 30);
    check("t1_errors", n_err, 0);

    // 2: same stream with ena toggling
    do_reset();
    feed(0, 1'b1);
    feed(1, 1'b1);
    run_rest(1'b1);
    check("t2_peaks", n_peak, 2);
    check("t2_valleys", n_valley, 2);
    check("t2_pv_count", n_pv, 1);
    check("t2_period", last_period, 30);
    check("t2_idle_pulses", n_idle_pulse, 0);
    check("t2_errors", n_err, 0);

    // 3: 15 -> 0 while rising
    do_reset();
    for (int v = 0; v <= 15; v++) feed(v, 1'b0);
    step(1'b1, 4'd0);
    check("t3_error_pulse", bus.error, 1);
    check("t3_unlocked", bus.locked, 0);
    step(1'b1, 4'd1);
    step(1'b1, 4'd2);
    check("t3_relocked", bus.locked, 1);
    for (int v = 3; v <= 15; v++) feed(v, 1'b0);
    for (int v = 14; v >= 0; v--) feed(v, 1'b0);
    feed(1, 1'b0);
    check("t3_valley1", n_valley, 1);
    check("t3_no_pv_yet", n_pv, 0);
    for (int v = 2; v <= 15; v++) feed(v, 1'b0);
    for (int v = 14; v >= 0; v--) feed(v, 1'b0);
    feed(1, 1'b0);
    check("t3_pv_after_2nd", n_pv, 1);
    check("t3_period", last_period, 30);
    check("t3_error_total", n_err, 1);

    // 4: mid-range reversal
    do_reset();
    step(1'b1, 4'd5);
    step(1'b1, 4'd6);
    step(1'b1, 4'd7);
    check("t4_locked_up", {bus.locked, bus.dir}, 3);
    step(1'b1, 4'd6);
    check("t4_reversal_err", bus.error, 1);
    check("t4_reversal_unlock", bus.locked, 0);
    step(1'b1, 4'd5);
    check("t4_locked_down", {bus.locked, bus.dir}, 2);
    check("t4_no_peak", n_peak, 0);

    // 5: async reset while falling
    do_reset();
    step(1'b1, 4'd12);
    step(1'b1, 4'd11);
    step(1'b1, 4'd10);
    step(1'b1, 4'd9);
    check("t5_locked_down", {bus.locked, bus.dir}, 2);
    rst = 1'b1;
    #1;
    check("t5_async_clear", bus.locked, 0);
    do_reset();
    step(1'b1, 4'd3);
    step(1'b1, 4'd4);
    check("t5_relock_up", {bus.locked, bus.dir}, 3);

    // 6: error counter
    do_reset();
    step(1'b1, 4'd5);
    step(1'b1, 4'd5);
    check("t6_repeat_err", bus.error, 1);
    step(1'b1, 4'd5);
    step(1'b1, 4'd5);
    check("t6_err_pulses", n_err, 3);
`ifdef TRI_CHECK_ERRCNT_EN
    check("t6_err_count", bus.err_count, 3);
`else
    check("t6_err_count", bus.err_count, 0);
`endif
    do_reset();
    check("t6_err_count_reset", bus.err_count, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule
